// File: rtl/cpu_pkg.sv
// Shared CPU definitions: widths, reset address and the resolved PC command.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package cpu_pkg;

    localparam int ADDR_W   = 6;
    localparam int BUS_W    = 8;
    localparam int PC_RESET = 0;

    // One command per cycle, after priority resolution (ret > call > ld > inc).
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        INC  = 3'd1,
        LD   = 3'd2,
        CALL = 3'd3,
        RET  = 3'd4
    } pc_cmd_t;

endpackage

// File: rtl/pc_unit_ret_stack.sv
// Return-address LIFO: push writes stack[sp], pop drops the top entry.
// Latency: push/pop take effect on the next rising edge; data_out is the current top.
// Backpressure: none; the caller must not push when full or pop when empty.
module ret_stack #(
    parameter int AW    = cpu_pkg::ADDR_W,
    parameter int DEPTH = 4,
    parameter int SPW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] data_in,
    output logic [AW-1:0] data_out,
    output logic [SPW-1:0] sp,
    output logic          full,
    output logic          empty
);

    localparam int IW = $clog2(DEPTH);

    logic [AW-1:0] mem [DEPTH];
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;

    // sp is the next free slot; the top entry sits one below it.
    assign wr_idx   = sp[IW-1:0];
    assign rd_idx   = wr_idx - IW'(1);
    assign data_out = mem[rd_idx];
    assign full     = (sp == SPW'(DEPTH));
    assign empty    = (sp == '0);

    // Occupancy and storage update; contents are cleared on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push && !full) begin
            mem[wr_idx] <= data_in;
            sp          <= sp + SPW'(1);
        end else if (pop && !empty) begin
            sp <= sp - SPW'(1);
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter with increment, jump, call/return and bus drive.
// Latency: every command is visible on pc one cycle later; bus_out/bus_oe are combinational.
// Backpressure: hold freezes all state; otherwise a command is accepted every cycle.
module pc_unit
    import cpu_pkg::*;
#(
    parameter int AW    = ADDR_W,
    parameter int DW    = BUS_W,
    parameter int DEPTH = 4,
    parameter int SPW   = $clog2(DEPTH) + 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           inc,
    input  logic           ld,
    input  logic           call,
    input  logic           ret,
    input  logic           hold,
    input  logic           oe,
    input  logic [DW-1:0]  bus_in,
    output logic [AW-1:0]  pc,
    output logic [DW-1:0]  bus_out,
    output logic           bus_oe,
    output logic           wrap,
    output logic           ovf,
    output logic           unf,
    output logic [SPW-1:0] sp
);

    pc_cmd_t       cmd;
    logic [AW-1:0] pc_next_seq;
    logic [AW-1:0] stk_top;
    logic          stk_full;
    logic          stk_empty;
    logic          stk_push;
    logic          stk_pop;
    logic          unused_bus_hi;

    // Upper bus bits never reach the address.
    assign unused_bus_hi = ^bus_in[DW-1:AW];
    assign pc_next_seq   = pc + AW'(1);

    // Resolve simultaneous requests to a single command: ret > call > ld > inc.
    always_comb begin
        cmd = IDLE;
        if (ret)       cmd = RET;
        else if (call) cmd = CALL;
        else if (ld)   cmd = LD;
        else if (inc)  cmd = INC;
    end

    assign stk_push = !hold && (cmd == CALL) && !stk_full;
    assign stk_pop  = !hold && (cmd == RET)  && !stk_empty;

    ret_stack #(
        .AW    (AW),
        .DEPTH (DEPTH),
        .SPW   (SPW)
    ) u_ret_stack (
        .clk      (clk),
        .rst      (rst),
        .push     (stk_push),
        .pop      (stk_pop),
        .data_in  (pc_next_seq),
        .data_out (stk_top),
        .sp       (sp),
        .full     (stk_full),
        .empty    (stk_empty)
    );

    // PC register, one-cycle wrap pulse and sticky stack error flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc   <= AW'(PC_RESET);
            wrap <= 1'b0;
            ovf  <= 1'b0;
            unf  <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (!hold) begin
                case (cmd)
                    INC: begin
                        pc   <= pc_next_seq;
                        wrap <= (pc == '1);
                    end
                    LD: pc <= bus_in[AW-1:0];
                    CALL: begin
                        if (stk_full) ovf <= 1'b1;
                        else          pc  <= bus_in[AW-1:0];
                    end
                    RET: begin
                        if (stk_empty) unf <= 1'b1;
                        else           pc  <= stk_top;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Bus drive is purely a view of pc; it never affects state.
    assign bus_oe  = oe;
    assign bus_out = oe ? {{(DW-AW){1'b0}}, pc} : '0;

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       inc = 1'b0, ld = 1'b0, call = 1'b0, ret = 1'b0, hold = 1'b0, oe = 1'b0;
    logic [7:0] bus_in = 8'h00;
    logic [5:0] pc;
    logic [7:0] bus_out;
    logic       bus_oe, wrap, ovf, unf;
    logic [2:0] sp;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model state
    int m_pc;
    int m_stk[$];
    bit m_wrap, m_ovf, m_unf;

    pc_unit dut (
        .clk(clk), .rst(rst), .inc(inc), .ld(ld), .call(call), .ret(ret),
        .hold(hold), .oe(oe), .bus_in(bus_in), .pc(pc), .bus_out(bus_out),
        .bus_oe(bus_oe), .wrap(wrap), .ovf(ovf), .unf(unf), .sp(sp)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       hold, inc, ld, call, ret;
        bit [7:0] bus;
        int       exp_pc;
        int       exp_sp;
        bit       exp_wrap;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_pc = 0;
        m_stk.delete();
        m_wrap = 0; m_ovf = 0; m_unf = 0;
    endtask

    // Behavioural rules applied to one edge.
    task automatic model_step(input bit h, input bit i, input bit l, input bit c,
                              input bit r, input int b);
        m_wrap = 0;
        if (h) return;
        if (r) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else m_unf = 1;
        end else if (c) begin
            if (m_stk.size() < 4) begin
                m_stk.push_back((m_pc + 1) % 64);
                m_pc = b % 64;
            end else m_ovf = 1;
        end else if (l) begin
            m_pc = b % 64;
        end else if (i) begin
            m_wrap = (m_pc == 63);
            m_pc = (m_pc + 1) % 64;
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".pc"},   int'(pc),   m_pc);
        chk({tag, ".sp"},   int'(sp),   m_stk.size());
        chk({tag, ".wrap"}, int'(wrap), int'(m_wrap));
        chk({tag, ".ovf"},  int'(ovf),  int'(m_ovf));
        chk({tag, ".unf"},  int'(unf),  int'(m_unf));
    endtask

    // Drive one command for one edge, then sample 1ns after the edge.
    task automatic step(input bit h, input bit i, input bit l, input bit c,
                        input bit r, input bit [7:0] b);
        @(negedge clk);
        hold = h; inc = i; ld = l; call = c; ret = r; bus_in = b;
        @(posedge clk);
        #1;
        model_step(h, i, l, c, r, int'(b));
        @(negedge clk);
        hold = 0; inc = 0; ld = 0; call = 0; ret = 0;
    endtask

    task automatic add(input bit h, input bit i, input bit l, input bit c, input bit r,
                       input bit [7:0] b, input int epc, input int esp, input bit ew);
        vec_t v;
        v.hold = h; v.inc = i; v.ld = l; v.call = c; v.ret = r; v.bus = b;
        v.exp_pc = epc; v.exp_sp = esp; v.exp_wrap = ew;
        vecs.push_back(v);
    endtask

    initial begin
        // hold inc ld call ret bus   pc   sp wrap
        add(0, 1, 0, 0, 0, 8'h00,  1,   0, 0);
        add(0, 1, 0, 0, 0, 8'h00,  2,   0, 0);
        add(0, 1, 0, 0, 0, 8'h00,  3,   0, 0);
        add(0, 0, 1, 0, 0, 8'hFF,  63,  0, 0);
        add(0, 1, 0, 0, 0, 8'h00,  0,   0, 1);
        add(0, 0, 0, 0, 0, 8'h00,  0,   0, 0);
        add(0, 0, 1, 0, 0, 8'h05,  5,   0, 0);
        add(0, 0, 0, 1, 0, 8'd20,  20,  1, 0);
        add(0, 1, 0, 0, 0, 8'h00,  21,  1, 0);
        add(0, 1, 0, 0, 0, 8'h00,  22,  1, 0);
        add(0, 0, 0, 0, 1, 8'h00,  6,   0, 0);
        add(1, 1, 0, 0, 0, 8'h00,  6,   0, 0);
        add(0, 0, 1, 0, 0, 8'h08,  8,   0, 0);
        add(0, 0, 0, 1, 0, 8'hC3,  3,   1, 0);
        add(0, 1, 0, 1, 1, 8'h11,  9,   0, 0);
        add(0, 0, 1, 0, 0, 8'h2A,  42,  0, 0);

        model_reset();
        #12;
        chk("reset.pc", int'(pc), 0);
        chk("reset.sp", int'(sp), 0);
        chk("reset.flags", int'({wrap, ovf, unf}), 0);
        rst = 1'b1;

        foreach (vecs[k]) begin
            step(vecs[k].hold, vecs[k].inc, vecs[k].ld, vecs[k].call, vecs[k].ret, vecs[k].bus);
            chk($sformatf("vec%0d.pc", k), int'(pc), vecs[k].exp_pc);
            chk($sformatf("vec%0d.sp", k), int'(sp), vecs[k].exp_sp);
            chk($sformatf("vec%0d.wrap", k), int'(wrap), int'(vecs[k].exp_wrap));
        end
        check_model("vec_end");

        // Bus drive at pc=0x2A
        @(negedge clk);
        oe = 1; #1;
        chk("oe1.bus_out", int'(bus_out), 8'h2A);
        chk("oe1.bus_oe", int'(bus_oe), 1);
        oe = 0; #1;
        chk("oe0.bus_out", int'(bus_out), 0);
        chk("oe0.bus_oe", int'(bus_oe), 0);
        step(0, 0, 0, 0, 0, 8'h00);
        chk("oe.pc_kept", int'(pc), 42);

        // Async reset mid-sequence, no clock edge needed
        step(0, 0, 0, 1, 0, 8'd7);
        step(0, 1, 0, 0, 0, 8'h00);
        #2 rst = 1'b0; #1;
        model_reset();
        chk("async_rst.pc", int'(pc), 0);
        chk("async_rst.sp", int'(sp), 0);
        chk("async_rst.flags", int'({wrap, ovf, unf}), 0);
        @(negedge clk); rst = 1'b1;
        step(0, 1, 0, 0, 0, 8'h00);
        chk("post_rst.first_inc", int'(pc), 1);

        // Nested calls, overflow, unwind, underflow, sticky flags
        step(0, 0, 1, 0, 0, 8'd5);
        step(0, 0, 0, 1, 0, 8'd10);
        step(0, 0, 0, 1, 0, 8'd20);
        step(0, 0, 0, 1, 0, 8'd30);
        step(0, 0, 0, 1, 0, 8'd40);
        chk("nest.sp_full", int'(sp), 4);
        step(0, 0, 0, 1, 0, 8'd50);
        chk("ovf.pc", int'(pc), 40);
        chk("ovf.flag", int'(ovf), 1);
        chk("ovf.sp", int'(sp), 4);
        step(0, 0, 0, 0, 1, 8'h00); chk("ret1.pc", int'(pc), 31);
        step(0, 0, 0, 0, 1, 8'h00); chk("ret2.pc", int'(pc), 21);
        step(0, 0, 0, 0, 1, 8'h00); chk("ret3.pc", int'(pc), 11);
        step(0, 0, 0, 0, 1, 8'h00); chk("ret4.pc", int'(pc), 6);
        step(0, 0, 0, 0, 1, 8'h00);
        chk("unf.pc", int'(pc), 6);
        chk("unf.flag", int'(unf), 1);
        step(0, 1, 0, 0, 0, 8'h00);
        step(0, 0, 1, 0, 0, 8'h01);
        chk("sticky.ovf", int'(ovf), 1);
        chk("sticky.unf", int'(unf), 1);
        check_model("nest_end");

        // Randomised run against the reference model
        @(negedge clk); rst = 1'b0; #1; model_reset(); rst = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            bit h, i, l, c, r;
            bit [7:0] b;
            h = ($urandom_range(0, 9) == 0);
            i = ($urandom_range(0, 1) == 1);
            l = ($urandom_range(0, 5) == 0);
            c = ($urandom_range(0, 4) == 0);
            r = ($urandom_range(0, 4) == 0);
            b = 8'($urandom);
            if ($urandom_range(0, 7) == 0) b = 8'h3F;
            step(h, i, l, c, r, b);
            check_model($sformatf("rnd%0d", n));
            oe = 1'($urandom_range(0, 1)); #1;
            chk($sformatf("rnd%0d.bus_out", n), int'(bus_out), oe ? m_pc : 0);
            chk($sformatf("rnd%0d.bus_oe", n), int'(bus_oe), int'(oe));
            oe = 0;
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b0; #1; model_reset();
                check_model($sformatf("rnd%0d.rst", n));
                rst = 1'b1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
